// File: rtl/rcn_pkg.sv
// Shared rcn ring word layout and Avalon response codes for the ordered
// Avalon-to-rcn bridge.
package rcn_pkg;

    localparam int unsigned RCN_W       = 69;
    localparam int unsigned RCN_VALID   = 68;
    localparam int unsigned RCN_PEND    = 67;
    localparam int unsigned RCN_WR      = 66;
    localparam int unsigned RCN_ID_HI   = 65;
    localparam int unsigned RCN_ID_LO   = 60;
    localparam int unsigned RCN_MASK_HI = 59;
    localparam int unsigned RCN_MASK_LO = 56;
    localparam int unsigned RCN_ADDR_HI = 55;
    localparam int unsigned RCN_ADDR_LO = 34;
    localparam int unsigned RCN_SEQ_HI  = 33;
    localparam int unsigned RCN_SEQ_LO  = 32;
    localparam int unsigned RCN_DATA_HI = 31;
    localparam int unsigned RCN_DATA_LO = 0;

    localparam logic [1:0] AV_RESP_OKAY    = 2'b00;
    localparam logic [1:0] AV_RESP_TIMEOUT = 2'b11;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } rcn_dir_e;

    // A request leaves with valid and pending both set; the responder clears pending.
    function automatic logic [RCN_W-1:0] rcn_request(
        input logic        wr,
        input logic [5:0]  id,
        input logic [3:0]  mask,
        input logic [21:0] addr,
        input logic [1:0]  seq,
        input logic [31:0] data
    );
        return {1'b1, 1'b1, wr, id, mask, addr, seq, data};
    endfunction

    function automatic logic [7:0] sat_add8(
        input logic [7:0] base,
        input logic [1:0] inc
    );
        logic [8:0] sum;
        sum = {1'b0, base} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/rcn_seq_tracker.sv
// Per-direction sequence tracker: issue/retire ids, abandon bitmap for
// timed-out slots and the oldest-transaction response timer.
module rcn_seq_tracker
    import rcn_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter logic [15:0] TIMEOUT = 16'd4096
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       issue_i,
    input  logic       accept_i,
    input  logic       scrub_i,
    input  logic [1:0] scrub_seq_i,
    output logic [1:0] seq_o,
    output logic [1:0] wait_seq_o,
    output logic [3:0] abandoned_o,
    output logic       full_o,
    output logic       blocked_o,
    output logic       timeout_o,
    output logic       busy_o
);

    localparam logic [2:0]  DEPTH_L    = 3'(DEPTH);
    localparam logic [15:0] TIMER_LAST = TIMEOUT - 16'd1;

    logic [2:0]  next_id_q, next_id_d;
    logic [2:0]  wait_id_q, wait_id_d;
    logic [3:0]  abandoned_q, abandoned_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  outstanding;

    assign outstanding = next_id_q - wait_id_q;

    assign seq_o       = next_id_q[1:0];
    assign wait_seq_o  = wait_id_q[1:0];
    assign abandoned_o = abandoned_q;
    assign full_o      = (outstanding >= DEPTH_L);
    assign blocked_o   = abandoned_q[next_id_q[1:0]];
    assign busy_o      = (outstanding != 3'd0) || (abandoned_q != 4'd0);

    // An accept in the same cycle retires the oldest slot, so it suppresses the timeout.
    assign timeout_o = (TIMEOUT != 16'd0) && (outstanding != 3'd0) && !accept_i &&
                       (timer_q == TIMER_LAST);

    always_comb begin
        next_id_d   = next_id_q;
        wait_id_d   = wait_id_q;
        abandoned_d = abandoned_q;
        timer_d     = timer_q;

        if (issue_i) begin
            next_id_d = next_id_q + 3'd1;
        end

        if (scrub_i) begin
            abandoned_d[scrub_seq_i] = 1'b0;
        end

        if (outstanding == 3'd0 || accept_i) begin
            timer_d = '0;
        end else if (timeout_o) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 16'd1;
        end

        if (accept_i) begin
            wait_id_d = wait_id_q + 3'd1;
        end else if (timeout_o) begin
            wait_id_d                 = wait_id_q + 3'd1;
            abandoned_d[wait_id_q[1:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            next_id_q   <= '0;
            wait_id_q   <= '0;
            abandoned_q <= '0;
            timer_q     <= '0;
        end else begin
            next_id_q   <= next_id_d;
            wait_id_q   <= wait_id_d;
            abandoned_q <= abandoned_d;
            timer_q     <= timer_d;
        end
    end

endmodule

// File: rtl/avalon2rcn_ordered.sv
// Avalon-MM slave to rcn ring master with up to 4 outstanding reads and
// writes, in-order completion, response timeouts and late-response scrubbing.
module avalon2rcn_ordered
    import rcn_pkg::*;
#(
    parameter logic [5:0]  MASTER_ID = 6'h3F,
    parameter int unsigned RD_DEPTH  = 4,
    parameter int unsigned WR_DEPTH  = 4,
    parameter logic [15:0] TIMEOUT   = 16'd4096,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic        av_clk,
    input  logic        av_rst,
    output logic        av_waitrequest,
    input  logic [21:0] av_address,
    input  logic        av_write,
    input  logic        av_read,
    input  logic [3:0]  av_byteenable,
    input  logic [31:0] av_writedata,
    output logic [31:0] av_readdata,
    output logic        av_readdatavalid,
    output logic [1:0]  av_response,
    input  logic [68:0] rcn_in,
    output logic [68:0] rcn_out,
    output logic [7:0]  err_count,
    output logic        busy
);

    logic [68:0] rin_q;
    logic [68:0] rout_q, rout_d;
    logic        rdv_q, rdv_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  resp_q, resp_d;
    logic [7:0]  err_q, err_d;

    logic [1:0] rd_seq, rd_wait_seq, wr_seq, wr_wait_seq;
    logic [3:0] rd_abandoned, wr_abandoned;
    logic       rd_full, rd_blocked, rd_timeout, rd_busy;
    logic       wr_full, wr_blocked, wr_timeout, wr_busy;

    logic       my_resp, rd_match, wr_match;
    logic [1:0] resp_seq;
    logic       accept_rd, accept_wr, scrub_rd, scrub_wr;
    logic       slot_free, req, dir_ok, issue, issue_rd, issue_wr;
    logic [1:0] req_seq;
    rcn_dir_e   dir;

    assign my_resp  = rin_q[RCN_VALID] && !rin_q[RCN_PEND] &&
                      (rin_q[RCN_ID_HI:RCN_ID_LO] == MASTER_ID);
    assign resp_seq = rin_q[RCN_SEQ_HI:RCN_SEQ_LO];
    assign rd_match = my_resp && !rin_q[RCN_WR];
    assign wr_match = my_resp &&  rin_q[RCN_WR];

    assign accept_rd = rd_match && (resp_seq == rd_wait_seq) && !rd_abandoned[resp_seq];
    assign accept_wr = wr_match && (resp_seq == wr_wait_seq) && !wr_abandoned[resp_seq];
    assign scrub_rd  = rd_match && rd_abandoned[resp_seq];
    assign scrub_wr  = wr_match && wr_abandoned[resp_seq];

    // Consumed responses free their ring slot for a new request this same cycle.
    assign slot_free = !rin_q[RCN_VALID] || accept_rd || accept_wr || scrub_rd || scrub_wr;

    assign req      = av_read || av_write;
    assign dir      = av_read ? DIR_RD : DIR_WR;
    assign dir_ok   = (dir == DIR_RD) ? (!rd_full && !rd_blocked) : (!wr_full && !wr_blocked);
    assign issue    = req && slot_free && dir_ok;
    assign issue_rd = issue && (dir == DIR_RD);
    assign issue_wr = issue && (dir == DIR_WR);
    assign req_seq  = (dir == DIR_RD) ? rd_seq : wr_seq;

    assign av_waitrequest = req && !issue;

    rcn_seq_tracker #(
        .DEPTH   (RD_DEPTH),
        .TIMEOUT (TIMEOUT)
    ) u_rd_trk (
        .clk_i       (av_clk),
        .rst_i       (av_rst),
        .issue_i     (issue_rd),
        .accept_i    (accept_rd),
        .scrub_i     (scrub_rd),
        .scrub_seq_i (resp_seq),
        .seq_o       (rd_seq),
        .wait_seq_o  (rd_wait_seq),
        .abandoned_o (rd_abandoned),
        .full_o      (rd_full),
        .blocked_o   (rd_blocked),
        .timeout_o   (rd_timeout),
        .busy_o      (rd_busy)
    );

    rcn_seq_tracker #(
        .DEPTH   (WR_DEPTH),
        .TIMEOUT (TIMEOUT)
    ) u_wr_trk (
        .clk_i       (av_clk),
        .rst_i       (av_rst),
        .issue_i     (issue_wr),
        .accept_i    (accept_wr),
        .scrub_i     (scrub_wr),
        .scrub_seq_i (resp_seq),
        .seq_o       (wr_seq),
        .wait_seq_o  (wr_wait_seq),
        .abandoned_o (wr_abandoned),
        .full_o      (wr_full),
        .blocked_o   (wr_blocked),
        .timeout_o   (wr_timeout),
        .busy_o      (wr_busy)
    );

    always_comb begin
        rout_d  = rin_q;
        rdv_d   = 1'b0;
        rdata_d = '0;
        resp_d  = AV_RESP_OKAY;

        if (issue) begin
            rout_d = rcn_request(av_write, MASTER_ID, av_byteenable, av_address,
                                 req_seq, av_writedata);
        end else if (accept_rd || accept_wr || scrub_rd || scrub_wr) begin
            rout_d = '0;
        end

        if (accept_rd) begin
            rdv_d   = 1'b1;
            rdata_d = rin_q[RCN_DATA_HI:RCN_DATA_LO];
        end else if (rd_timeout) begin
            rdv_d   = 1'b1;
            rdata_d = ERR_DATA;
            resp_d  = AV_RESP_TIMEOUT;
        end

        err_d = sat_add8(err_q, {1'b0, rd_timeout} + {1'b0, wr_timeout});
    end

    always_ff @(posedge av_clk) begin
        if (av_rst) begin
            rin_q   <= '0;
            rout_q  <= '0;
            rdv_q   <= 1'b0;
            rdata_q <= '0;
            resp_q  <= AV_RESP_OKAY;
            err_q   <= '0;
        end else begin
            rin_q   <= rcn_in;
            rout_q  <= rout_d;
            rdv_q   <= rdv_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    assign rcn_out          = rout_q;
    assign av_readdatavalid = rdv_q;
    assign av_readdata      = rdata_q;
    assign av_response      = resp_q;
    assign err_count        = err_q;
    assign busy             = rd_busy || wr_busy;

endmodule

// File: tb/tb_avalon2rcn_ordered.sv
// Directed bench for avalon2rcn_ordered with RD/WR_DEPTH=2 and TIMEOUT=16;
// the bench plays the ring by driving rcn_in directly.
module tb_avalon2rcn_ordered;

    logic        av_clk = 1'b0;
    logic        av_rst = 1'b1;
    logic        av_waitrequest;
    logic [21:0] av_address = '0;
    logic        av_write = 1'b0;
    logic        av_read = 1'b0;
    logic [3:0]  av_byteenable = '0;
    logic [31:0] av_writedata = '0;
    logic [31:0] av_readdata;
    logic        av_readdatavalid;
    logic [1:0]  av_response;
    logic [68:0] rcn_in = '0;
    logic [68:0] rcn_out;
    logic [7:0]  err_count;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;
    int cyc;
    int rdv_seen;

    avalon2rcn_ordered #(
        .MASTER_ID (6'h3F),
        .RD_DEPTH  (2),
        .WR_DEPTH  (2),
        .TIMEOUT   (16'd16),
        .ERR_DATA  (32'hDEADBEEF)
    ) dut (
        .av_clk           (av_clk),
        .av_rst           (av_rst),
        .av_waitrequest   (av_waitrequest),
        .av_address       (av_address),
        .av_write         (av_write),
        .av_read          (av_read),
        .av_byteenable    (av_byteenable),
        .av_writedata     (av_writedata),
        .av_readdata      (av_readdata),
        .av_readdatavalid (av_readdatavalid),
        .av_response      (av_response),
        .rcn_in           (rcn_in),
        .rcn_out          (rcn_out),
        .err_count        (err_count),
        .busy             (busy)
    );

    always #5 av_clk = ~av_clk;

    task automatic tick();
        @(posedge av_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [68:0] resp_word(input logic wr, input logic [1:0] seq,
                                              input logic [31:0] data);
        return {1'b1, 1'b0, wr, 6'h3F, 4'hF, 22'h0, seq, data};
    endfunction

    function automatic logic [68:0] foreign_word(input int unsigned i);
        return {1'b1, 1'b0, 1'b0, 6'h05, 4'hA, 22'h00ABC, 2'b01, 32'h5000_0000 + i};
    endfunction

    task automatic do_reset();
        av_rst = 1'b1;
        rcn_in = '0;
        av_read = 1'b0;
        av_write = 1'b0;
        tick();
        tick();
        av_rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_rcn_out", rcn_out, 69'd0);
        check("rst_rdv", av_readdatavalid, 0);
        check("rst_err", err_count, 0);
        check("rst_busy", busy, 0);
        check("rst_waitreq", av_waitrequest, 0);

        // Single read, response 5 cycles later
        av_read = 1'b1; av_address = 22'h012345; av_byteenable = 4'hF; av_writedata = '0;
        #1 check("t1_waitreq", av_waitrequest, 0);
        tick();
        av_read = 1'b0;
        check("t1_req", rcn_out, {1'b1, 1'b1, 1'b0, 6'h3F, 4'hF, 22'h012345, 2'b00, 32'h0});
        check("t1_busy", busy, 1);
        repeat (4) tick();
        rcn_in = resp_word(1'b0, 2'd0, 32'h12345678);
        tick();
        rcn_in = '0;
        check("t1_rdv_early", av_readdatavalid, 0);
        tick();
        check("t1_rdv", av_readdatavalid, 1);
        check("t1_rdata", av_readdata, 32'h12345678);
        check("t1_resp", av_response, 2'b00);
        check("t1_slot_cleared", rcn_out, 69'd0);
        tick();
        check("t1_rdv_pulse", av_readdatavalid, 0);
        check("t1_idle", busy, 0);

        // Depth limit: third read stalls until first response accepted
        do_reset();
        av_read = 1'b1; av_address = 22'h000001;
        tick();
        check("t2_seq0", rcn_out[33:32], 0);
        av_address = 22'h000002;
        #1 check("t2_wr_b", av_waitrequest, 0);
        tick();
        check("t2_seq1", rcn_out[33:32], 1);
        av_address = 22'h000003;
        #1 check("t2_stall", av_waitrequest, 1);
        rcn_in = resp_word(1'b0, 2'd0, 32'h000000A0);
        tick();
        rcn_in = '0;
        #1 check("t2_still_full", av_waitrequest, 1);
        tick();
        check("t2_rdv", av_readdatavalid, 1);
        check("t2_rdata", av_readdata, 32'h000000A0);
        #1 check("t2_release", av_waitrequest, 0);
        tick();
        av_read = 1'b0;
        check("t2_seq2", rcn_out, {1'b1, 1'b1, 1'b0, 6'h3F, 4'hF, 22'h000003, 2'b10, 32'h0});

        // Out-of-order return: seq 2 passes through, seq 1 completes, then seq 2
        rcn_in = resp_word(1'b0, 2'd2, 32'h000000C2);
        tick();
        rcn_in = resp_word(1'b0, 2'd1, 32'h000000B1);
        tick();
        check("t3_passthru", rcn_out, resp_word(1'b0, 2'd2, 32'h000000C2));
        check("t3_no_rdv", av_readdatavalid, 0);
        rcn_in = resp_word(1'b0, 2'd2, 32'h000000C2);
        tick();
        rcn_in = '0;
        check("t3_rdv_b", av_readdatavalid, 1);
        check("t3_rdata_b", av_readdata, 32'h000000B1);
        check("t3_slot_b", rcn_out, 69'd0);
        tick();
        check("t3_rdv_c", av_readdatavalid, 1);
        check("t3_rdata_c", av_readdata, 32'h000000C2);
        tick();
        check("t3_idle", busy, 0);

        // Read timeout
        do_reset();
        av_read = 1'b1; av_address = 22'h000004;
        tick();
        av_read = 1'b0;
        check("t4_seq0", rcn_out[33:32], 0);
        cyc = 0;
        while (!av_readdatavalid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("t4_latency", cyc, 16);
        check("t4_rdata", av_readdata, 32'hDEADBEEF);
        check("t4_resp", av_response, 2'b11);
        check("t4_err", err_count, 1);
        check("t4_busy", busy, 1);
        tick();
        check("t4_pulse", av_readdatavalid, 0);

        // Late response for the abandoned read is scrubbed
        rcn_in = resp_word(1'b0, 2'd0, 32'h00000055);
        tick();
        rcn_in = '0;
        tick();
        check("t5_scrub_slot", rcn_out, 69'd0);
        check("t5_no_rdv", av_readdatavalid, 0);
        check("t5_not_busy", busy, 0);
        av_read = 1'b1; av_address = 22'h000005;
        tick();
        av_read = 1'b0;
        check("t5_seq1", rcn_out[33:32], 1);
        rcn_in = resp_word(1'b0, 2'd1, 32'h00000077);
        tick();
        rcn_in = '0;
        tick();
        check("t5_rdv", av_readdatavalid, 1);
        check("t5_rdata", av_readdata, 32'h00000077);
        check("t5_resp", av_response, 2'b00);

        // Write request and write accept
        av_write = 1'b1; av_address = 22'h000003; av_byteenable = 4'h3;
        av_writedata = 32'hCAFEF00D;
        #1 check("t6_waitreq", av_waitrequest, 0);
        tick();
        av_write = 1'b0;
        check("t6_req", rcn_out, {1'b1, 1'b1, 1'b1, 6'h3F, 4'h3, 22'h000003, 2'b00, 32'hCAFEF00D});
        check("t6_busy", busy, 1);
        rcn_in = resp_word(1'b1, 2'd0, 32'h0);
        tick();
        rcn_in = '0;
        tick();
        check("t6_slot", rcn_out, 69'd0);
        check("t6_no_rdv", av_readdatavalid, 0);
        check("t6_idle", busy, 0);

        // Foreign traffic every cycle blocks issue and passes through
        rcn_in = foreign_word(0);
        tick();
        av_write = 1'b1; av_writedata = 32'h11111111;
        for (int unsigned i = 1; i <= 6; i++) begin
            rcn_in = foreign_word(i);
            #1 check("t7_stall", av_waitrequest, 1);
            tick();
            check("t7_fwd", rcn_out, foreign_word(i - 1));
        end
        av_write = 1'b0;
        rcn_in = '0;
        tick();
        check("t7_no_issue", busy, 0);

        // Write timeout: counted, no Avalon completion
        av_write = 1'b1; av_address = 22'h000006;
        tick();
        av_write = 1'b0;
        rdv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (av_readdatavalid) rdv_seen++;
        end
        check("t8_no_rdv", rdv_seen, 0);
        check("t8_err", err_count, 2);
        check("t8_busy", busy, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
